// File: rtl/riscv_muldiv.sv
// RV32M multiply/divide execute unit: pipelined multiplier plus an iterative
// restoring divider that stalls issue while it works.
module riscv_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [2:0]      opcode_func_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            flush_i,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_idx_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic            stall_o
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t state, state_next;

    logic accept, mul_accept, div_accept;

    assign stall_o    = (state != IDLE);
    assign accept     = opcode_valid_i & ~stall_o & ~flush_i;
    assign mul_accept = accept & ~opcode_func_i[2];
    assign div_accept = accept & opcode_func_i[2];

    // Sign-extending to 2*XLEN lets one unsigned multiply serve all four variants.
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] a_wide, b_wide, product;
    logic [XLEN-1:0]   mul_result;

    always_comb begin
        a_sext     = ((opcode_func_i[1:0] == 2'd1) | (opcode_func_i[1:0] == 2'd2))
                     & opcode_ra_operand_i[XLEN-1];
        b_sext     = (opcode_func_i[1:0] == 2'd1) & opcode_rb_operand_i[XLEN-1];
        a_wide     = {{XLEN{a_sext}}, opcode_ra_operand_i};
        b_wide     = {{XLEN{b_sext}}, opcode_rb_operand_i};
        product    = a_wide * b_wide;
        mul_result = (opcode_func_i[1:0] == 2'd0) ? product[XLEN-1:0]
                                                  : product[2*XLEN-1:XLEN];
    end

    logic            mul_last_valid;
    logic [4:0]      mul_last_rd;
    logic [XLEN-1:0] mul_last_value;

    // The writeback register is the final multiply stage, so only LATENCY-1 live here.
    generate
        if (MUL_LATENCY > 1) begin : g_mul_pipe
            localparam int D = MUL_LATENCY - 1;
            logic [D-1:0]    valid_q;
            logic [4:0]      rd_q    [D];
            logic [XLEN-1:0] value_q [D];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    valid_q <= '0;
                    for (int i = 0; i < D; i++) begin
                        rd_q[i]    <= '0;
                        value_q[i] <= '0;
                    end
                end else begin
                    for (int i = D - 1; i > 0; i--) begin
                        valid_q[i] <= valid_q[i-1] & ~flush_i;
                        rd_q[i]    <= rd_q[i-1];
                        value_q[i] <= value_q[i-1];
                    end
                    valid_q[0] <= mul_accept;
                    rd_q[0]    <= opcode_rd_idx_i;
                    value_q[0] <= mul_result;
                end
            end

            assign mul_last_valid = valid_q[D-1];
            assign mul_last_rd    = rd_q[D-1];
            assign mul_last_value = value_q[D-1];
        end else begin : g_mul_direct
            assign mul_last_valid = mul_accept;
            assign mul_last_rd    = opcode_rd_idx_i;
            assign mul_last_value = mul_result;
        end
    endgenerate

    logic [CW-1:0]   count;
    logic [XLEN-1:0] quot, rem, divisor;
    logic            q_neg, r_neg, div_zero, want_rem;
    logic [4:0]      div_rd;
    logic            div_signed;
    logic [XLEN-1:0] ra_abs, rb_abs;
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] q_final, r_final, div_result;

    always_comb begin
        div_signed = ~opcode_func_i[0];
        ra_abs     = (div_signed & opcode_ra_operand_i[XLEN-1]) ? -opcode_ra_operand_i
                                                                : opcode_ra_operand_i;
        rb_abs     = (div_signed & opcode_rb_operand_i[XLEN-1]) ? -opcode_rb_operand_i
                                                                : opcode_rb_operand_i;
        shifted    = {rem, quot[XLEN-1]};
        trial      = shifted - {1'b0, divisor};
        // A zero divisor leaves an all-ones quotient that must not be negated.
        q_final    = (q_neg & ~div_zero) ? -quot : quot;
        r_final    = r_neg ? -rem : rem;
        div_result = want_rem ? r_final : q_final;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (div_accept) state_next = RUN;
                RUN:     if (count == CW'(1)) state_next = FIXUP;
                FIXUP:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count    <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            want_rem <= 1'b0;
            div_rd   <= '0;
        end else if (div_accept) begin
            count    <= CW'(XLEN);
            quot     <= ra_abs;
            rem      <= '0;
            divisor  <= rb_abs;
            q_neg    <= div_signed & (opcode_ra_operand_i[XLEN-1] ^ opcode_rb_operand_i[XLEN-1]);
            r_neg    <= div_signed & opcode_ra_operand_i[XLEN-1];
            div_zero <= (opcode_rb_operand_i == '0);
            want_rem <= opcode_func_i[1];
            div_rd   <= opcode_rd_idx_i;
        end else if (state == RUN) begin
            quot  <= {quot[XLEN-2:0], ~trial[XLEN]};
            rem   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            writeback_valid_o <= 1'b0;
            writeback_idx_o   <= '0;
            writeback_value_o <= '0;
        end else if (flush_i) begin
            writeback_valid_o <= 1'b0;
            writeback_idx_o   <= '0;
            writeback_value_o <= '0;
        end else if (state == FIXUP) begin
            writeback_valid_o <= 1'b1;
            writeback_idx_o   <= div_rd;
            writeback_value_o <= div_result;
        end else if (mul_last_valid) begin
            writeback_valid_o <= 1'b1;
            writeback_idx_o   <= mul_last_rd;
            writeback_value_o <= mul_last_value;
        end else begin
            writeback_valid_o <= 1'b0;
            writeback_idx_o   <= '0;
            writeback_value_o <= '0;
        end
    end

endmodule
